// File: rtl/lift_call_register.sv
// ---------------------------------------------------------------------------
// lift_call_register
//
// Turns debounced button levels into latched floor requests, clears a request
// when the car services that floor, tracks sweep direction (IDLE/UP/DOWN) and
// presents the next target floor using the SCAN rule: keep moving in the
// current direction while work remains ahead, otherwise reverse or go idle.
//
// Ports
//   clk        : system clock, everything on the rising edge
//   resetb     : synchronous, active-high reset (1 = reset)
//   cleansw    : debounced button levels, bit i = floor i
//   cur_floor  : floor the car is at or passing
//   serve      : car stopped with doors open at cur_floor (level)
//   req        : pending-request vector
//   new_req    : one-cycle pulse when at least one request bit is newly set
//   req_valid  : any request pending (registered alongside next_floor)
//   next_floor : selected target floor
//   dir        : sweep state, 00 IDLE, 01 UP, 10 DOWN; this is the FSM state
//                register itself, so it doubles as the state debug view
//
// Output qualification: next_floor is meaningful to the motion controller
// only while req_valid is high, or while dir is UP/DOWN. There is no
// backpressure; the consumer samples every cycle.
// ---------------------------------------------------------------------------
module lift_call_register #(
  parameter int NFLOORS = 4,
  parameter int FLW     = 2
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic [NFLOORS-1:0] cleansw,
  input  logic [FLW-1:0]     cur_floor,
  input  logic               serve,
  output logic [NFLOORS-1:0] req,
  output logic               new_req,
  output logic               req_valid,
  output logic [FLW-1:0]     next_floor,
  output logic [1:0]         dir
);

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_t;

  dir_t               state;
  dir_t               state_nxt;
  logic [NFLOORS-1:0] prev;
  logic [NFLOORS-1:0] press;
  logic [NFLOORS-1:0] clr;
  logic               above;
  logic               below;
  logic               here;
  logic [FLW-1:0]     up_tgt;
  logic [FLW-1:0]     dn_tgt;
  logic [FLW-1:0]     tgt_nxt;
  int                 cur_i;

  assign dir = state;

  // Request bookkeeping, direction decision and target selection.
  // A cur_floor outside 0..NFLOORS-1 never matches a floor index, so it
  // clears nothing and no bit counts as "here"; it still classifies every
  // pending floor as below, which keeps the car heading back into range.
  always_comb begin
    cur_i  = int'(cur_floor);
    press  = cleansw & ~prev;
    clr    = '0;
    above  = 1'b0;
    below  = 1'b0;
    here   = 1'b0;
    up_tgt = '0;
    dn_tgt = '0;

    for (int j = 0; j < NFLOORS; j++) begin
      if (serve && (j == cur_i)) clr[j] = 1'b1;
      if (req[j] && (j >  cur_i)) above = 1'b1;
      if (req[j] && (j <  cur_i)) below = 1'b1;
      if (req[j] && (j == cur_i)) here  = 1'b1;
    end

    // Descending scan: the last hit is the lowest pending floor above.
    for (int j = NFLOORS - 1; j >= 0; j--) begin
      if (req[j] && (j > cur_i)) up_tgt = FLW'(j);
    end

    // Ascending scan: the last hit is the highest pending floor below.
    for (int j = 0; j < NFLOORS; j++) begin
      if (req[j] && (j < cur_i)) dn_tgt = FLW'(j);
    end

    // SCAN direction rule.
    state_nxt = state;
    case (state)
      DIR_IDLE: begin
        if (above)      state_nxt = DIR_UP;
        else if (below) state_nxt = DIR_DOWN;
        else            state_nxt = DIR_IDLE;
      end
      DIR_UP: begin
        if (above)      state_nxt = DIR_UP;
        else if (below) state_nxt = DIR_DOWN;
        else            state_nxt = DIR_IDLE;
      end
      DIR_DOWN: begin
        if (below)      state_nxt = DIR_DOWN;
        else if (above) state_nxt = DIR_UP;
        else            state_nxt = DIR_IDLE;
      end
      default:          state_nxt = DIR_IDLE;
    endcase

    // Target follows the direction being entered this cycle. UP/DOWN are
    // only entered when a matching request exists, so the target is always
    // a real floor. IDLE keeps the last target unless the car's own floor
    // is pending.
    tgt_nxt = next_floor;
    case (state_nxt)
      DIR_UP:   tgt_nxt = up_tgt;
      DIR_DOWN: tgt_nxt = dn_tgt;
      default: begin
        if (here) tgt_nxt = cur_floor;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetb) begin
      prev       <= '0;
      req        <= '0;
      new_req    <= 1'b0;
      req_valid  <= 1'b0;
      next_floor <= '0;
      state      <= DIR_IDLE;
    end else begin
      prev       <= cleansw;
      // Clear beats a simultaneous press at the same floor.
      req        <= (req | press) & ~clr;
      // Pulse only for bits that actually become set this cycle.
      new_req    <= |(press & ~req & ~clr);
      req_valid  <= |req;
      next_floor <= tgt_nxt;
      state      <= state_nxt;
    end
  end

endmodule

// File: doc/lift_call_register.md
# lift_call_register

Request-holding and target-selection stage placed directly downstream of the per-button switch debouncers in the lift controller. It turns debounced button levels into latched floor requests and clears each request when the car services that floor. It tracks sweep direction with a small UP/DOWN/IDLE state machine and presents the next target floor to the motion controller, using the SCAN rule: keep going while work remains ahead.

## Interface
- NFLOORS, 4, number of floors/buttons (2..16)
- FLW, 2, floor index width, ≥ clog2(NFLOORS)
- clk  input  1  system clock, all logic on rising edge
- resetb  input  1  reset: one clock; reset is synchronous and active-high (1 = reset, sampled on clk rising edge)
- cleansw  input  NFLOORS  debounced button levels, bit i = floor i
- cur_floor  input  FLW  floor the car is at or passing
- serve  input  1  level; car stopped with doors open at cur_floor
- req  output  NFLOORS  pending-request vector
- new_req  output  1  one-cycle pulse: at least one request bit newly set
- req_valid  output  1  any request pending
- next_floor  output  FLW  selected target floor
- dir  output  2  sweep state: 00 IDLE, 01 UP, 10 DOWN (11 never driven)

## Operation
- Edge detect: prev register holds last cleansw; press_i = cleansw[i] & ~prev[i]. Releases are ignored. A held button registers once.
- Request update: req[i] <= (req[i] | press_i) & ~clr_i, with clr_i = serve & (cur_floor == i). Clear wins over a simultaneous press at the same floor.
- cur_floor ≥ NFLOORS: clr is inactive, and no bit is treated as "at" the car.
- new_req = |(press & ~req & ~clr), registered.
- above = any req[j] with j > cur_floor; below = any req[j] with j < cur_floor; here = req[cur_floor]. All three are computed from registered req.
- FSM (registered, updated every cycle):
  - IDLE: above → UP. Else below → DOWN. Else stay.
  - UP: above → stay. Else below → DOWN. Else IDLE.
  - DOWN: below → stay. Else above → UP. Else IDLE.
  - The FSM uses the next-state value to select the target in the same cycle.
- next_floor selection, registered:
  - UP: lowest pending j > cur_floor.
  - DOWN: highest pending j < cur_floor.
  - IDLE: cur_floor if here, else holds its previous value.
- req_valid = |req, registered alongside next_floor.
- Reset: req = 0, prev = 0, new_req = 0, req_valid = 0, next_floor = 0, dir = IDLE.
- A button already high when reset releases registers as a press in the first cycle after reset. The debouncers also reset their outputs to 0, so this is consistent.

## Timing
- Press latency:
  - cleansw[i] rises before edge n → req[i] = 1 and new_req = 1 after edge n.
  - req_valid, dir and next_floor update after edge n+1.
- Clear latency: serve sampled at edge n with cur_floor = i → req[i] = 0 after edge n. dir and next_floor reflect it after edge n+1.
- new_req is high for exactly one cycle per press event. Presses on several floors in the same cycle produce one pulse.
- Reset asserted mid-operation: at the next edge all state returns to reset values, and pending requests are discarded.
- cur_floor may change on any cycle. Outputs follow it with 1-cycle latency.
- next_floor is never a floor outside 0..NFLOORS-1.

## Test plan
- Reset with cleansw = 0 → req = 0000, dir = 00, next_floor = 0, req_valid = 0. Then a cleansw = 0001 rise → req = 0001 and new_req pulse one cycle later, with no second pulse while held.
- cur_floor = 0, press floors 2 and 3 in the same cycle → req = 1100, one new_req pulse, dir = UP, next_floor = 2.
- Continuing: cur_floor = 2, serve = 1 → req = 1000, dir stays UP, next_floor = 3. Then cur_floor = 3, serve → req = 0000, dir = IDLE, req_valid = 0.
- SCAN reversal: cur_floor = 2, dir = UP, req = 1001 → next_floor = 3. After floor 3 is served, dir = DOWN, next_floor = 0.
- serve = 1 at cur_floor = 1 in the same cycle as a floor-1 press → req[1] stays 0, new_req = 0.
- Reset asserted for one cycle with req = 0110 and dir = DOWN → all outputs at reset values after that edge, no new_req pulse.
